// File: rtl/psram_pkg.sv
// psram_pkg: commands, FSM state type, counter widths and lane helpers for the QSPI PSRAM controller
package psram_pkg;
  localparam logic [7:0] CMD_QREAD = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;
  localparam int SCK_CNT_W = 6;
  localparam int HOLD_CNT_W = 8;
  typedef enum logic [2:0] {IDLE, HOLDOFF, CMD, ADDR, WAIT, RDATA, WDATA, DONE} state_t;
  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction
  function automatic logic [1:0] lo_lane(input logic [3:0] s);
    return s[0] ? 2'd0 : s[1] ? 2'd1 : s[2] ? 2'd2 : 2'd3;
  endfunction
  function automatic logic [1:0] hi_lane(input logic [3:0] s);
    return s[3] ? 2'd3 : s[2] ? 2'd2 : s[1] ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/qspi_psram_shifter.sv
// qspi_psram_shifter: SCK phase toggle, SCK-cycle down-counter and 1/4-bit shift register with nibble capture
module qspi_psram_shifter
  import psram_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 quad,
  input  logic                 cap,
  input  logic [31:0]          load_data,
  input  logic [SCK_CNT_W-1:0] load_cnt,
  input  logic [3:0]           sio_in,
  output logic                 phase,
  output logic                 last,
  output logic [31:0]          sr
);
  logic [SCK_CNT_W-1:0] cnt;
  assign last = phase && cnt == SCK_CNT_W'(1);
  always_ff @(posedge clk)
    if (rst) begin
      phase <= 1'b0;
      cnt <= '0;
      sr <= '0;
    end else if (load) begin
      phase <= 1'b0;
      cnt <= load_cnt;
      sr <= load_data;
    end else if (run) begin
      phase <= !phase;
      if (phase) begin
        cnt <= cnt - 1'b1;
        if (shift) sr <= quad ? {sr[27:0], 4'b0} : {sr[30:0], 1'b0};
      end else if (cap) begin
        sr <= {sr[27:0], sio_in};
      end
    end
endmodule

// File: rtl/qspi_psram_ctrl.sv
// qspi_psram_ctrl: 32-bit valid/ready to QSPI quad-read (0xEB) / quad-write (0x38) PSRAM initiator, SCK = clk/2
module qspi_psram_ctrl
  import psram_pkg::*;
#(
  parameter int CE_HIGH_CYCLES = 2,
  parameter int WAIT_CYCLES = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  output logic        ready,
  input  logic [23:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] rdata,
  output logic        ce_n,
  output logic        sclk,
  output logic [3:0]  sio_out,
  output logic [3:0]  sio_oe,
  input  logic [3:0]  sio_in
);
  state_t state, state_nx;
  logic [HOLD_CNT_W-1:0] hcnt;
  logic phase, last, load, rd, act, unused_ok;
  logic [31:0] sr, load_data;
  logic [SCK_CNT_W-1:0] load_cnt;
  logic [1:0] lo, hi;
  logic [2:0] n;
  assign unused_ok = ^addr[1:0];
  assign rd = wstrb == 4'b0;
  assign lo = lo_lane(wstrb);
  assign hi = hi_lane(wstrb);
  assign n = {1'b0, hi} - {1'b0, lo} + 3'd1;
  assign act = state inside {CMD, ADDR, WAIT, RDATA, WDATA};
  assign ce_n = !act;
  assign sclk = phase;
  assign ready = state == DONE;
  assign sio_oe = state == CMD ? 4'b0001 : state inside {ADDR, WDATA} ? 4'b1111 : 4'b0000;
  assign sio_out = !act ? 4'b0 : state == CMD ? {3'b0, sr[31]} : sr[31:28];
  qspi_psram_shifter u_shifter (
    .clk(clk),
    .rst(rst),
    .run(act),
    .load(load),
    .shift(state inside {CMD, ADDR, WDATA}),
    .quad(state != CMD),
    .cap(state == RDATA),
    .load_data(load_data),
    .load_cnt(load_cnt),
    .sio_in(sio_in),
    .phase(phase),
    .last(last),
    .sr(sr)
  );
  always_comb begin
    state_nx = state;
    load = 1'b0;
    load_data = '0;
    load_cnt = '0;
    case (state)
      HOLDOFF: state_nx = int'(hcnt) + 1 >= CE_HIGH_CYCLES ? IDLE : HOLDOFF;
      IDLE: if (valid && int'(hcnt) >= CE_HIGH_CYCLES) begin
        state_nx = CMD;
        load = 1'b1;
        load_data = {rd ? CMD_QREAD : CMD_QWRITE, 24'b0};
        load_cnt = SCK_CNT_W'(8);
      end
      CMD: if (last) begin
        state_nx = ADDR;
        load = 1'b1;
        load_data = {addr[23:2], rd ? 2'b00 : lo, 8'b0};
        load_cnt = SCK_CNT_W'(6);
      end
      ADDR: if (last) begin
        state_nx = !rd ? WDATA : WAIT_CYCLES > 0 ? WAIT : RDATA;
        load = 1'b1;
        load_data = bswap(wdata >> {lo, 3'b0});
        load_cnt = !rd ? SCK_CNT_W'({n, 1'b0}) : WAIT_CYCLES > 0 ? SCK_CNT_W'(WAIT_CYCLES) : SCK_CNT_W'(8);
      end
      WAIT: if (last) begin
        state_nx = RDATA;
        load = 1'b1;
        load_cnt = SCK_CNT_W'(8);
      end
      RDATA, WDATA: if (last) state_nx = DONE;
      DONE: state_nx = HOLDOFF;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= HOLDOFF;
      hcnt <= '0;
      rdata <= '0;
    end else begin
      state <= state_nx;
      hcnt <= state == DONE ? HOLD_CNT_W'(1) : state == HOLDOFF ? hcnt + 1'b1 : hcnt;
      if (state == RDATA && last) rdata <= bswap(sr);
    end
  always_ff @(posedge clk)
    if (!rst && state == IDLE && valid && !rd)
      assert (wstrb inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
endmodule

// File: tb/tb_qspi_psram_ctrl.sv
// tb_qspi_psram_ctrl: table-driven scoreboard bench with a behavioural QSPI PSRAM model
module tb_qspi_psram_ctrl;
  localparam int CE_HIGH = 2;
  typedef struct {
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [7:0]  cmd;
    logic [23:0] xaddr;
    logic [31:0] xdata;
    int          nib;
    int          rcyc;
  } vec_t;
  logic clk = 0, rst = 1, valid = 0, ready, ce_n, sclk;
  logic [23:0] addr = 0;
  logic [31:0] wdata = 0, rdata, last_rd = 0;
  logic [3:0] wstrb = 0, sio_out, sio_oe, sio_in;
  logic [7:0] mem [0:511];
  logic [7:0] m_cmd;
  logic [23:0] m_addr;
  logic [31:0] m_wnib;
  int m_nib, t_ce = 0, cyc = 0, tests = 0, fails = 0;
  bit m_oe_bad;
  vec_t sb[$];
  qspi_psram_ctrl #(.CE_HIGH_CYCLES(CE_HIGH), .WAIT_CYCLES(6)) dut (
    .clk(clk),
    .rst(rst),
    .valid(valid),
    .ready(ready),
    .addr(addr),
    .wdata(wdata),
    .wstrb(wstrb),
    .rdata(rdata),
    .ce_n(ce_n),
    .sclk(sclk),
    .sio_out(sio_out),
    .sio_oe(sio_oe),
    .sio_in(sio_in)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end
  initial begin
    int k, j;
    logic ce_prev;
    logic [7:0] b;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    ce_prev = 1'b1;
    k = 0;
    sio_in = 4'h0;
    forever begin
      @(negedge clk);
      if (!ce_n && ce_prev) begin
        t_ce = cyc;
        k = 0;
        m_cmd = 0;
        m_addr = 0;
        m_wnib = 0;
        m_nib = 0;
        m_oe_bad = 0;
      end
      ce_prev = ce_n;
      if (!ce_n && sclk) begin
        if (sio_oe != (k < 8 ? 4'h1 : (k < 14 || m_cmd == 8'h38) ? 4'hF : 4'h0)) m_oe_bad = 1;
        if (k < 8) m_cmd = {m_cmd[6:0], sio_out[0]};
        else if (k < 14) m_addr = {m_addr[19:0], sio_out};
        else if (m_cmd == 8'h38) begin
          j = k - 14;
          m_wnib = {m_wnib[27:0], sio_out};
          m_nib++;
          if (j % 2 == 1) mem[9'(m_addr[8:0] + 9'(j / 2))] = m_wnib[7:0];
        end
        k++;
        j = k - 20;
        if (m_cmd == 8'hEB && j >= 0 && j < 8) begin
          b = mem[9'(m_addr[8:0] + 9'(j / 2))];
          sio_in = j % 2 == 1 ? b[3:0] : b[7:4];
        end else begin
          sio_in = 4'($urandom);
        end
      end
    end
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run_txn(input vec_t t, input bit now);
    vec_t e;
    bit got;
    if (!now) @(negedge clk);
    valid = 1;
    addr = t.addr;
    wdata = t.wdata;
    wstrb = t.wstrb;
    sb.push_back(t);
    got = 0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      got = ready;
    end
    valid = 0;
    e = sb.pop_front();
    check("ready_seen", 32'(got), 1);
    if (got) begin
      check("ready_cycle", 32'(cyc - t_ce + 1), 32'(e.rcyc));
      check("cmd", 32'(m_cmd), 32'(e.cmd));
      check("addr", 32'(m_addr), 32'(e.xaddr));
      check("oe_ok", 32'(m_oe_bad), 0);
      if (e.wstrb == 4'b0) begin
        check("rdata", rdata, e.xdata);
        last_rd = e.xdata;
      end else begin
        check("wnibbles", m_wnib, e.xdata);
        check("wnib_count", 32'(m_nib), 32'(e.nib));
        check("rdata_hold", rdata, last_rd);
      end
      @(negedge clk);
      check("ready_pulse", 32'(ready), 0);
    end
  endtask
  initial begin
    vec_t v[13];
    int rel, n, nrdy;
    v[0]  = '{24'h000100, 32'hDEADBEEF, 4'b1111, 8'h38, 24'h000100, 32'hEFBEADDE, 8, 45};
    v[1]  = '{24'h000100, 32'h00000000, 4'b0000, 8'hEB, 24'h000100, 32'hDEADBEEF, 0, 57};
    v[2]  = '{24'h000104, 32'h11223344, 4'b1111, 8'h38, 24'h000104, 32'h44332211, 8, 45};
    v[3]  = '{24'h000104, 32'h00AA0000, 4'b0100, 8'h38, 24'h000106, 32'h000000AA, 2, 33};
    v[4]  = '{24'h000104, 32'h00000000, 4'b0000, 8'hEB, 24'h000104, 32'h11AA3344, 0, 57};
    v[5]  = '{24'h000108, 32'hBEEF0000, 4'b1100, 8'h38, 24'h00010A, 32'h0000EFBE, 4, 37};
    v[6]  = '{24'h00010B, 32'h00000055, 4'b0001, 8'h38, 24'h000108, 32'h00000055, 2, 33};
    v[7]  = '{24'h00010C, 32'h12345678, 4'b0011, 8'h38, 24'h00010C, 32'h00007856, 4, 37};
    v[8]  = '{24'h00010C, 32'h9A000000, 4'b1000, 8'h38, 24'h00010F, 32'h0000009A, 2, 33};
    v[9]  = '{24'h000109, 32'h00000000, 4'b0000, 8'hEB, 24'h000108, 32'hBEEF0055, 0, 57};
    v[10] = '{24'h00010E, 32'h00000000, 4'b0000, 8'hEB, 24'h00010C, 32'h9A005678, 0, 57};
    v[11] = '{24'h00010C, 32'hCAFEF00D, 4'b0010, 8'h38, 24'h00010D, 32'h000000F0, 2, 33};
    v[12] = '{24'h00010C, 32'h00000000, 4'b0000, 8'hEB, 24'h00010C, 32'h9A00F078, 0, 57};
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ce_n", 32'(ce_n), 1);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_sio_oe", 32'(sio_oe), 0);
    check("rst_sio_out", 32'(sio_out), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_rdata", rdata, 0);
    rel = cyc;
    rst = 0;
    run_txn(v[0], 1);
    check("holdoff_after_reset", 32'(t_ce - rel >= CE_HIGH + 1), 1);
    for (int i = 1; i < 13; i++) run_txn(v[i], 0);
    @(negedge clk);
    valid = 1;
    addr = 24'h000100;
    wstrb = 4'b0000;
    n = 0;
    for (int c = 0; c < 100 && n < 20; c++) begin
      @(negedge clk);
      if (!ce_n) n++;
    end
    check("mid_reach_cycle20", 32'(n), 20);
    rst = 1;
    valid = 0;
    @(negedge clk);
    check("mid_rst_ce_n", 32'(ce_n), 1);
    check("mid_rst_sclk", 32'(sclk), 0);
    check("mid_rst_sio_oe", 32'(sio_oe), 0);
    check("mid_rst_ready", 32'(ready), 0);
    rst = 0;
    last_rd = 0;
    nrdy = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (ready) nrdy++;
    end
    check("mid_rst_no_ready", 32'(nrdy), 0);
    run_txn(v[1], 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
